// File: rtl/abs_neg_pipe_pkg.sv
// ---------------------------------------------------------------------------
// lau_pkg : shared types for the abs/negate pipeline.
//   absneg_mode_e : per-beat operation select (PASS / NEG / ABS / NABS)
//   speed_e       : prefix-network structure select for PrefixAnd
//   negate_en()   : per-lane "complement and add one" enable for a mode
// ---------------------------------------------------------------------------
package lau_pkg;

    typedef enum logic [1:0] {
        PASS = 2'b00,
        NEG  = 2'b01,
        ABS  = 2'b10,
        NABS = 2'b11
    } absneg_mode_e;

    typedef enum logic {
        SLOW = 1'b0,
        FAST = 1'b1
    } speed_e;

    // ABS negates only negative operands, NABS only non-negative ones.
    function automatic logic negate_en(absneg_mode_e mode, logic sign);
        logic n;
        unique case (mode)
            PASS:    n = 1'b0;
            NEG:     n = 1'b1;
            ABS:     n = sign;
            NABS:    n = ~sign;
            default: n = 1'b0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/abs_neg_pipe_if.sv
// ---------------------------------------------------------------------------
// abs_neg_pipe_if : valid/ready stream bundle for abs_neg_pipe.
//   valid_i / ready_o / mode_i / A_i : input beat (upstream -> unit)
//   valid_o / ready_i / Z_o / ovf_o  : output beat (unit -> downstream)
//   modport slave  : the unit side
//   modport master : the environment side (producer + consumer)
// ---------------------------------------------------------------------------
interface abs_neg_pipe_if #(
    parameter int width = 8,
    parameter int lanes = 1
) ();
    import lau_pkg::*;

    logic                   valid_i;
    logic                   ready_o;
    absneg_mode_e           mode_i;
    logic [lanes*width-1:0] A_i;
    logic                   valid_o;
    logic                   ready_i;
    logic [lanes*width-1:0] Z_o;
    logic [lanes-1:0]       ovf_o;

    modport slave (
        input  valid_i, mode_i, A_i, ready_i,
        output ready_o, valid_o, Z_o, ovf_o
    );

    modport master (
        output valid_i, mode_i, A_i, ready_i,
        input  ready_o, valid_o, Z_o, ovf_o
    );

endinterface

// File: rtl/abs_neg_pipe_lane.sv
// ---------------------------------------------------------------------------
// abs_neg_lane : combinational per-lane sign manipulation.
//   mode : operation (PASS / NEG / ABS / NABS)
//   a    : 2's-complement operand
//   z    : result, mod 2^width
//   ovf  : set when the most-negative operand is negated (NEG or ABS)
// Z = (A ^ {w{n}}) + n, with the +n done as an incrementer whose carries
// come from a prefix AND over {A ^ {w{n}}, n}.
// Build option ABS_NEG_SAT_EN: overflowing lanes saturate to max positive
// instead of wrapping to the most-negative value.
// ---------------------------------------------------------------------------
module abs_neg_lane
    import lau_pkg::*;
#(
    parameter int     width = 8,
    parameter speed_e speed = FAST
) (
    input  absneg_mode_e     mode,
    input  logic [width-1:0] a,
    output logic [width-1:0] z,
    output logic             ovf
);

    logic             n;
    logic [width-1:0] x;
    logic [width:0]   carry;
    logic [width-1:0] sum;
    logic             unused_carry_out;

    assign n = negate_en(mode, a[width-1]);
    assign x = a ^ {width{n}};

    // carry[i] = n & x[0] & ... & x[i-1]: the carry into bit i of x + n.
    PrefixAnd #(
        .width (width + 1),
        .speed (speed)
    ) u_prefix (
        .pi ({x, n}),
        .po (carry)
    );

    assign sum              = x ^ carry[width-1:0];
    assign unused_carry_out = carry[width];

    // carry[width-1] means the low width-1 bits of a are all zero; with the
    // sign set and a negate requested that is exactly the most-negative input.
    assign ovf = n & a[width-1] & carry[width-1];

`ifdef ABS_NEG_SAT_EN
    assign z = ovf ? {1'b0, {(width-1){1'b1}}} : sum;
`else
    assign z = sum;
`endif

endmodule

// File: rtl/abs_neg_pipe_prefix.sv
// ---------------------------------------------------------------------------
// PrefixAnd : parallel-prefix AND, po[i] = &pi[i:0].
//   pi : input vector (width bits)
//   po : inclusive prefix AND of pi
// speed = FAST builds a Kogge-Stone network (log2 depth); SLOW leaves each
// output as a plain reduction and lets synthesis share terms.
// ---------------------------------------------------------------------------
module PrefixAnd
    import lau_pkg::*;
#(
    parameter int     width = 9,
    parameter speed_e speed = FAST
) (
    input  logic [width-1:0] pi,
    output logic [width-1:0] po
);

    localparam int levels = (width > 1) ? $clog2(width) : 1;

    generate
        if (speed == FAST) begin : g_fast
            genvar gl, gi;
            for (gl = 0; gl < levels; gl++) begin : g_lvl
                logic [width-1:0] prev;
                logic [width-1:0] row;
                if (gl == 0) begin : g_first
                    assign prev = pi;
                end else begin : g_next
                    assign prev = g_lvl[gl-1].row;
                end
                for (gi = 0; gi < width; gi++) begin : g_bit
                    // Combine with the span ending 2^gl bits lower, if any.
                    if (gi >= (1 << gl)) begin : g_comb
                        assign row[gi] = prev[gi] & prev[gi-(1<<gl)];
                    end else begin : g_pass
                        assign row[gi] = prev[gi];
                    end
                end
            end
            assign po = g_lvl[levels-1].row;
        end else begin : g_slow
            genvar gi;
            for (gi = 0; gi < width; gi++) begin : g_bit
                assign po[gi] = &pi[gi:0];
            end
        end
    endgenerate

endmodule

// File: rtl/abs_neg_pipe.sv
// ---------------------------------------------------------------------------
// abs_neg_pipe : multi-lane pipelined pass / negate / |A| / -|A| unit.
//   clk_i  : clock, all state on the rising edge
//   rst_ni : asynchronous active-low reset (clears valids and data)
//   bus    : abs_neg_pipe_if.slave stream bundle
//            valid_i/ready_o/mode_i/A_i in, valid_o/ready_i/Z_o/ovf_o out
// Lanes are computed combinationally at the input and travel through
// `stages` elastic register slices; latency is `stages` cycles with no
// backpressure, throughput one beat per cycle.
// Build option ABS_NEG_SAT_EN (in abs_neg_lane): saturate overflow lanes.
// ---------------------------------------------------------------------------
module abs_neg_pipe
    import lau_pkg::*;
#(
    parameter int     width  = 8,
    parameter int     lanes  = 1,
    parameter int     stages = 1,
    parameter speed_e speed  = FAST
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    abs_neg_pipe_if.slave  bus
);

    logic [lanes*width-1:0] lane_z;
    logic [lanes-1:0]       lane_ovf;

    logic [stages-1:0]      valid_reg;
    logic [lanes*width-1:0] z_reg   [stages];
    logic [lanes-1:0]       ovf_reg [stages];

    logic [stages-1:0]      load;
    logic [stages-1:0]      stage_in_valid;
    logic [lanes*width-1:0] stage_in_z   [stages];
    logic [lanes-1:0]       stage_in_ovf [stages];

    genvar gi;

    generate
        for (gi = 0; gi < lanes; gi++) begin : g_lane
            abs_neg_lane #(
                .width (width),
                .speed (speed)
            ) u_lane (
                .mode (bus.mode_i),
                .a    (bus.A_i[gi*width +: width]),
                .z    (lane_z[gi*width +: width]),
                .ovf  (lane_ovf[gi])
            );
        end

        for (gi = 0; gi < stages; gi++) begin : g_stage
            // A stage may take new content when the output is being released
            // or there is a bubble at or after it: everything downstream
            // shifts along, so a hole always opens up for it.
            assign load[gi] = bus.ready_i | ~(&valid_reg[stages-1:gi]);

            if (gi == 0) begin : g_head
                assign stage_in_valid[gi] = bus.valid_i;
                assign stage_in_z[gi]     = lane_z;
                assign stage_in_ovf[gi]   = lane_ovf;
            end else begin : g_body
                assign stage_in_valid[gi] = valid_reg[gi-1];
                assign stage_in_z[gi]     = z_reg[gi-1];
                assign stage_in_ovf[gi]   = ovf_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_reg <= '0;
            for (int s = 0; s < stages; s++) begin
                z_reg[s]   <= '0;
                ovf_reg[s] <= '0;
            end
        end else begin
            for (int s = 0; s < stages; s++) begin
                if (load[s]) begin
                    valid_reg[s] <= stage_in_valid[s];
                end
                // Data only moves with a real beat; bubbles leave it untouched.
                if (load[s] && stage_in_valid[s]) begin
                    z_reg[s]   <= stage_in_z[s];
                    ovf_reg[s] <= stage_in_ovf[s];
                end
            end
        end
    end

    assign bus.ready_o = load[0];
    assign bus.valid_o = valid_reg[stages-1];
    assign bus.Z_o     = z_reg[stages-1];
    assign bus.ovf_o   = ovf_reg[stages-1];

endmodule

// File: tb/tb_abs_neg_pipe.sv
// ---------------------------------------------------------------------------
// tb_abs_neg_pipe : self-checking bench for abs_neg_pipe (8-bit, 2 lanes,
// 2 stages). Expected beats are queued on input accept and compared at the
// output; valid_o timing and ready_o are predicted from queue occupancy.
// ---------------------------------------------------------------------------
module tb_abs_neg_pipe;
    import lau_pkg::*;

    localparam int WIDTH  = 8;
    localparam int LANES  = 2;
    localparam int STAGES = 2;
    localparam int DW     = LANES * WIDTH;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    abs_neg_pipe_if #(.width(WIDTH), .lanes(LANES)) bus ();

    abs_neg_pipe #(
        .width  (WIDTH),
        .lanes  (LANES),
        .stages (STAGES),
        .speed  (FAST)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    typedef struct {
        logic [DW-1:0]    z;
        logic [LANES-1:0] ovf;
        int unsigned      t;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;
    int          vcount = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference by signed integer arithmetic: {ovf, z}.
    function automatic logic [WIDTH:0] ref_lane(absneg_mode_e m, logic [WIDTH-1:0] a);
        int            sa;
        int            r;
        logic          ov;
        logic [WIDTH-1:0] z;
        sa = int'($signed(a));
        case (m)
            PASS:    r = sa;
            NEG:     r = -sa;
            ABS:     r = (sa < 0) ? -sa : sa;
            default: r = (sa < 0) ? sa : -sa;
        endcase
        ov = (sa == -(1 << (WIDTH-1))) && (m == NEG || m == ABS);
        z  = r[WIDTH-1:0];
`ifdef ABS_NEG_SAT_EN
        if (ov) z = {1'b0, {(WIDTH-1){1'b1}}};
`endif
        return {ov, z};
    endfunction

    function automatic exp_t ref_beat(absneg_mode_e m, logic [DW-1:0] a);
        exp_t           e;
        logic [WIDTH:0] r;
        for (int k = 0; k < LANES; k++) begin
            r = ref_lane(m, a[k*WIDTH +: WIDTH]);
            e.z[k*WIDTH +: WIDTH] = r[WIDTH-1:0];
            e.ovf[k]              = r[WIDTH];
        end
        e.t = 0;
        return e;
    endfunction

    // One clock cycle: drive at negedge, check before the posedge, update model.
    task automatic step(input logic v, input absneg_mode_e m, input logic [DW-1:0] a,
                        input logic rdy, output logic accepted);
        logic exp_valid;
        logic fire_in;
        logic fire_out;
        exp_t e;
        bus.valid_i = v;
        bus.mode_i  = m;
        bus.A_i     = a;
        bus.ready_i = rdy;
        #1;
        exp_valid = (sb.size() > 0) && ((cyc - sb[0].t) >= STAGES - 1);
        check("valid_o", bus.valid_o, exp_valid);
        check("ready_o", bus.ready_o, !(sb.size() == STAGES && !rdy));
        if (exp_valid) begin
            check("Z_o", bus.Z_o, sb[0].z);
            check("ovf_o", bus.ovf_o, sb[0].ovf);
        end
        if (bus.valid_o === 1'b1) vcount++;
        fire_in  = v && bus.ready_o && rst_n;
        fire_out = exp_valid && rdy && rst_n;
        @(posedge clk);
        cyc++;
        if (fire_out) void'(sb.pop_front());
        if (fire_in) begin
            e   = ref_beat(m, a);
            e.t = cyc;
            sb.push_back(e);
        end
        accepted = fire_in;
        @(negedge clk);
    endtask

    task automatic send(input absneg_mode_e m, input logic [DW-1:0] a, input int pct,
                        output int tries);
        logic acc;
        tries = 0;
        acc   = 1'b0;
        while (!acc && tries < 100) begin
            step(1'b1, m, a, ($urandom_range(0, 99) < pct), acc);
            tries++;
        end
        if (!acc) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain(input int pct);
        int   n;
        logic acc;
        n = 0;
        while (sb.size() > 0 && n < 200) begin
            step(1'b0, PASS, '0, ($urandom_range(0, 99) < pct), acc);
            n++;
        end
        check("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        int         tries;
        logic       acc;
        logic [7:0] b;

        bus.valid_i = 1'b0;
        bus.mode_i  = PASS;
        bus.A_i     = '0;
        bus.ready_i = 1'b0;

        // 1: reset held with valid_i asserted
        #1;
        check("rst_valid_o", bus.valid_o, 1'b0);
        check("rst_Z_o", bus.Z_o, 32'd0);
        check("rst_ovf_o", bus.ovf_o, 32'd0);
        repeat (3) step(1'b1, NEG, 16'h8080, 1'b1, acc);
        rst_n = 1'b1;
        step(1'b0, PASS, '0, 1'b1, acc);

        // 2: all modes on 0x05 / 0xFB
        for (int i = 0; i < 4; i++) send(absneg_mode_e'(i), 16'hFB05, 100, tries);
        drain(100);

        // 3: overflow cases
        send(ABS,  16'h8080, 100, tries);
        send(NEG,  16'h8005, 100, tries);
        send(NABS, 16'h0580, 100, tries);
        drain(100);

        // 4: zero / edge operands
        send(NEG,  16'h0000, 100, tries);
        send(NABS, 16'h7F7F, 100, tries);
        send(ABS,  16'h0101, 100, tries);
        send(PASS, 16'h807F, 100, tries);
        drain(100);

        // 5: 10-beat ramp under random backpressure
        for (int i = 0; i < 10; i++) begin
            b = 8'h7C + 8'(i);
            send(absneg_mode_e'(i % 4), {b + 8'h04, b}, 50, tries);
        end
        drain(50);

        // 6: back-to-back burst, then reset mid-stream
        vcount = 0;
        for (int i = 0; i < 8; i++) begin
            b = 8'hF0 + 8'(i * 5);
            send(absneg_mode_e'(i % 4), {b, ~b}, 100, tries);
            check("burst_no_stall", tries, 1);
        end
        drain(100);
        check("burst_beats", vcount, 8);

        for (int i = 0; i < 4; i++) send(ABS, 16'hC3A5 + 16'(i), 100, tries);
        rst_n = 1'b0;
        #1;
        check("midrst_valid_o", bus.valid_o, 1'b0);
        check("midrst_Z_o", bus.Z_o, 32'd0);
        check("midrst_ovf_o", bus.ovf_o, 32'd0);
        sb.delete();
        repeat (2) step(1'b1, NEG, 16'h1234, 1'b1, acc);
        rst_n = 1'b1;
        vcount = 0;
        repeat (4) step(1'b0, PASS, '0, 1'b1, acc);
        check("no_stale_beat", vcount, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
